// File: rtl/ysyx_23060332_ifu_if.sv
// Fetch-unit bus bundle: imem request/response, decode handoff and redirect.
interface ysyx_23060332_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;

  // IFU side
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid_o, inst_o, inst_addr_o,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready_i,
           jump_en_i, jump_addr_i
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid_o, inst_o, inst_addr_o,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready_i,
           jump_en_i, jump_addr_i
  );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM (REQ -> WAIT -> HOLD)
// with redirect support; stale fetches are drained and discarded.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  ysyx_23060332_ifu_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pending_pc, w_pending_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_inst_valid, w_inst_valid_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_addr, w_inst_addr_nxt;

  logic [31:0] w_target;
  logic        w_drop_eff;

  assign w_target   = {bus.jump_addr_i[31:2], 2'b00};
  // A redirect arriving with the response also makes that response stale.
  assign w_drop_eff = r_drop | bus.jump_en_i;

  // Next-state and register-update logic
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pending_pc_nxt = r_pending_pc;
    w_drop_nxt       = r_drop;
    w_inst_valid_nxt = r_inst_valid;
    w_inst_nxt       = r_inst;
    w_inst_addr_nxt  = r_inst_addr;
    case (r_state)
      S_REQ: begin
        if (bus.jump_en_i) begin
          w_pending_pc_nxt = w_target;
          w_drop_nxt       = 1'b1;
        end
        if (bus.imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.jump_en_i) begin
          w_pending_pc_nxt = w_target;
          w_drop_nxt       = 1'b1;
        end
        if (bus.imem_resp_valid) begin
          if (w_drop_eff) begin
            // Latest redirect wins, including one arriving this cycle.
            w_pc_nxt    = bus.jump_en_i ? w_target : r_pending_pc;
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_inst_nxt       = bus.imem_resp_data;
            w_inst_addr_nxt  = r_pc;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // With ready the instruction is delivered; without it, it is killed.
        if (bus.jump_en_i || bus.inst_ready_i) begin
          w_inst_valid_nxt = 1'b0;
          w_inst_nxt       = NOP_INST;
          w_pc_nxt         = bus.jump_en_i ? w_target : r_pc + 32'd4;
          w_state_nxt      = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_pending_pc <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_addr  <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_addr  <= w_inst_addr_nxt;
    end
  end

  assign bus.imem_req_valid = (r_state == S_REQ) & ~rst;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid_o   = r_inst_valid;
  assign bus.inst_o         = r_inst;
  assign bus.inst_addr_o    = r_inst_addr;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for the fetch unit: per-cycle vector table plus a wrap sequence.
module tb_ysyx_23060332_ifu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060332_ifu_if bus ();

  ysyx_23060332_ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_ready;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_inst_valid;
    logic [31:0] e_inst;
    logic [31:0] e_inst_addr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h8000_0000;

  function automatic vec_t mk(logic r, logic rr, logic rv, logic [31:0] rd,
                              logic ir, logic je, logic [31:0] ja,
                              logic erv, logic [31:0] era, logic eiv,
                              logic [31:0] ei, logic [31:0] eia);
    vec_t v;
    v.rst = r; v.req_ready = rr; v.resp_valid = rv; v.resp_data = rd;
    v.inst_ready = ir; v.jump_en = je; v.jump_addr = ja;
    v.e_req_valid = erv; v.e_req_addr = era; v.e_inst_valid = eiv;
    v.e_inst = ei; v.e_inst_addr = eia;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rr, input logic rv,
                       input logic [31:0] rd, input logic ir, input logic je,
                       input logic [31:0] ja);
    rst = r;
    bus.imem_req_ready  = rr;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rd;
    bus.inst_ready_i    = ir;
    bus.jump_en_i       = je;
    bus.jump_addr_i     = ja;
  endtask

  task automatic chk_outs(input int idx, input logic erv, input logic [31:0] era,
                          input logic eiv, input logic [31:0] ei,
                          input logic [31:0] eia);
    chk("req_valid",  idx, {31'd0, bus.imem_req_valid}, {31'd0, erv});
    if (erv) chk("req_addr", idx, bus.imem_req_addr, era);
    chk("inst_valid", idx, {31'd0, bus.inst_valid_o}, {31'd0, eiv});
    chk("inst",       idx, bus.inst_o, ei);
    chk("inst_addr",  idx, bus.inst_addr_o, eia);
  endtask

  initial begin
    //             rst rr rv data          ir je jaddr          | rv addr          iv inst          iaddr
    // reset
    vecs.push_back(mk(1,0,0,0,            0,0,0,              0,RPC,           0,NOP,          RPC));
    vecs.push_back(mk(1,0,0,0,            0,0,0,              0,RPC,           0,NOP,          RPC));
    // basic fetch
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,RPC,           0,NOP,          RPC));
    vecs.push_back(mk(0,0,1,32'h00100093, 0,0,0,              0,0,             0,NOP,          RPC));
    vecs.push_back(mk(0,0,0,0,            1,0,0,              0,0,             1,32'h00100093, RPC));
    // imem_req_ready low 3 cycles
    vecs.push_back(mk(0,0,0,0,            0,0,0,              1,32'h80000004,  0,NOP,          RPC));
    vecs.push_back(mk(0,0,0,0,            0,0,0,              1,32'h80000004,  0,NOP,          RPC));
    vecs.push_back(mk(0,0,0,0,            0,0,0,              1,32'h80000004,  0,NOP,          RPC));
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,32'h80000004,  0,NOP,          RPC));
    vecs.push_back(mk(0,0,1,32'h00200113, 0,0,0,              0,0,             0,NOP,          RPC));
    // decode backpressure 5 cycles
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,          0,0,0,              0,0,             1,32'h00200113, 32'h80000004));
    vecs.push_back(mk(0,0,0,0,            1,0,0,              0,0,             1,32'h00200113, 32'h80000004));
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,32'h80000008,  0,NOP,          32'h80000004));
    // redirect in WAIT: response discarded, refetch at aligned target
    vecs.push_back(mk(0,0,0,0,            0,1,32'h80000102,   0,0,             0,NOP,          32'h80000004));
    vecs.push_back(mk(0,0,1,32'hDEADBEEF, 0,0,0,              0,0,             0,NOP,          32'h80000004));
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,32'h80000100,  0,NOP,          32'h80000004));
    vecs.push_back(mk(0,0,1,32'h00300193, 0,0,0,              0,0,             0,NOP,          32'h80000004));
    // redirect in HOLD without ready: killed
    vecs.push_back(mk(0,0,0,0,            0,1,32'h80000200,   0,0,             1,32'h00300193, 32'h80000100));
    vecs.push_back(mk(0,0,0,0,            0,0,0,              1,32'h80000200,  0,NOP,          32'h80000100));
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,32'h80000200,  0,NOP,          32'h80000100));
    vecs.push_back(mk(0,0,1,32'h00400213, 0,0,0,              0,0,             0,NOP,          32'h80000100));
    // redirect in HOLD with ready: delivered once, next req at target
    vecs.push_back(mk(0,0,0,0,            1,1,32'h80000300,   0,0,             1,32'h00400213, 32'h80000200));
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,32'h80000300,  0,NOP,          32'h80000200));
    // reset asserted in WAIT
    vecs.push_back(mk(1,0,0,0,            0,0,0,              0,0,             0,NOP,          32'h80000200));
    // stray response in REQ is ignored
    vecs.push_back(mk(0,0,1,32'hBADBAD00, 0,0,0,              1,RPC,           0,NOP,          RPC));
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,RPC,           0,NOP,          RPC));
    vecs.push_back(mk(0,0,1,32'h00500293, 0,0,0,              0,0,             0,NOP,          RPC));
    vecs.push_back(mk(0,0,0,0,            0,1,32'hFFFFFFFF,   0,0,             1,32'h00500293, RPC));
    // redirect in REQ with same-cycle accept, then overwritten in WAIT
    vecs.push_back(mk(0,1,0,0,            0,1,32'h80000010,   1,32'hFFFFFFFC,  0,NOP,          RPC));
    vecs.push_back(mk(0,0,0,0,            0,1,32'h80000020,   0,0,             0,NOP,          RPC));
    vecs.push_back(mk(0,0,1,32'h11111111, 0,0,0,              0,0,             0,NOP,          RPC));
    vecs.push_back(mk(0,1,0,0,            0,0,0,              1,32'h80000020,  0,NOP,          RPC));
    vecs.push_back(mk(0,0,1,32'h00600313, 0,0,0,              0,0,             0,NOP,          RPC));
    vecs.push_back(mk(0,0,0,0,            1,0,0,              0,0,             1,32'h00600313, 32'h80000020));
    vecs.push_back(mk(0,0,0,0,            0,0,0,              1,32'h80000024,  0,NOP,          32'h80000020));

    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].req_ready, vecs[i].resp_valid, vecs[i].resp_data,
            vecs[i].inst_ready, vecs[i].jump_en, vecs[i].jump_addr);
      #1;
      chk_outs(i, vecs[i].e_req_valid, vecs[i].e_req_addr, vecs[i].e_inst_valid,
               vecs[i].e_inst, vecs[i].e_inst_addr);
    end

    // PC wrap: redirect to 0xFFFFFFFC, fetch it, then next request is at 0
    @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);             // accept 0x80000024
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 32'hFFFFFFFE);  // redirect in WAIT
    @(negedge clk); drive(0, 0, 1, 32'h00700393, 0, 0, 0);  // discarded
    @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0); #1;
    chk("wrap_req_addr", 100, bus.imem_req_addr, 32'hFFFFFFFC);
    @(negedge clk); drive(0, 0, 1, 32'h00800413, 0, 0, 0);
    // bounded wait for the instruction
    begin
      int n = 0;
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
      while (!bus.inst_valid_o && n < 10) begin
        @(negedge clk); #1; n++;
      end
      chk("wrap_timeout", 101, {31'd0, bus.inst_valid_o}, 32'd1);
    end
    chk("wrap_inst",      102, bus.inst_o, 32'h00800413);
    chk("wrap_inst_addr", 103, bus.inst_addr_o, 32'hFFFFFFFC);
    bus.inst_ready_i = 1'b1;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("wrap_pc_zero", 104, bus.imem_req_addr, 32'h0000_0000);
    chk("wrap_req_valid", 105, {31'd0, bus.imem_req_valid}, 32'd1);
    chk("wrap_deliver_once", 106, {31'd0, bus.inst_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
